multicycle_main_control: RTL
============================

Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle datapath. Sits directly upstream of the ALU-control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Emits datapath enables, mux selects and the 2-bit alu_op that the ALU-control decoder combines with funct.
- Supports memory wait states via mem_ready; halts on an illegal opcode.

Parameters:
- OPC_W, 6, opcode width.
- ST_W, 4, state register width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when ALU zero is set.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register-file write data: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU operand B: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_op  out  2  to ALU control: 00 = add, 01 = subtract, 10 = use funct.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state, for debug.
- illegal_op  out  1  high while in TRAP.

Behaviour:
- Reset: asynchronous, active-low, on clk. rst_n=0 forces state=IDLE and clears the latched opcode.
- In IDLE all outputs are 0, including alu_op=00 and illegal_op=0.
- Deassertion mid-instruction abandons that instruction; there are no partial writes after reset.
- IDLE lasts one cycle, then goes to FETCH.
- All outputs are Moore (decoded from state) except the two FETCH strobes noted below. Unlisted outputs are 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready, so the PC increments exactly once per fetch.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Latches opcode internally; all later decisions use the latched copy.
  - Next state by opcode:
    - 000000 -> EXEC_R
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EX
    - any other -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next is FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next is FETCH.
- JUMP: pc_write=1, pc_source=10. Next is FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next is ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next is FETCH.
- TRAP: illegal_op=1, all other outputs 0. Absorbing; only rst_n exits.
- Latency with mem_ready tied high, counted from FETCH entry to the next FETCH entry:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.
  - Each extra cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle; outputs stay stable while waiting.
- mem_ready is ignored in every state except FETCH, MEM_RD and MEM_WR.
- Unused state encodings (14, 15) go to TRAP.
- Invariants:
  - mem_read and mem_write are never both 1.
  - reg_write is never asserted in the same cycle as any pc_write.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, TRAP=13;
  - opcode constants;
  - alu_op encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), shared with the ALU-control decoder;
  - alu_src_b and pc_source encodings.
- One natural sub-module: main_ctrl_outdec, a purely combinational state-to-outputs decoder.
- The next-state logic and state register stay in the top module.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release -> one IDLE cycle with all outputs 0, then state=1 with mem_read=1 and alu_op=00.
- R-type with mem_ready=1 and opcode=000000 -> states 1,2,7,8,1; alu_op=10 in EXEC_R; reg_write=1 with reg_dst=1 in R_WB; pc_write=1 in exactly one cycle.
- lw with opcode=100011 and mem_ready low for 2 cycles in MEM_RD -> states 1,2,3,4,4,4,5,1; mem_read held 3 cycles; MEM_WB has mem_to_reg=1 and reg_write=1.
- Fetch stall: mem_ready=0 for 4 cycles in FETCH -> ir_write=0 and pc_write=0 throughout; exactly one cycle of ir_write=pc_write=1 when mem_ready rises.
- beq (000100), then j (000010) -> BRANCH has alu_op=01, pc_write_cond=1, pc_source=01; JUMP has pc_write=1, pc_source=10; each takes 3 cycles.
- Illegal opcode 111111 at DECODE -> state=13 and illegal_op=1 held for 20+ cycles; asserting rst_n=0 mid-TRAP returns to IDLE asynchronously (before the next edge).

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
// Holds the main-control state encodings, the opcodes the controller
// recognises, the alu_op encoding shared with the ALU-control decoder,
// the alu_src_b / pc_source mux encodings and the bundled control word
// produced by the state-to-outputs decoder.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // alu_op encoding, consumed by the ALU-control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/main_ctrl_outdec.sv
// Combinational state-to-outputs decoder for the main control FSM.
// Ports:
//   state     in   current FSM state
//   mem_ready in   memory handshake; only used to gate the FETCH strobes
//   ctrl      out  bundled datapath enables, mux selects and alu_op
module main_ctrl_outdec
    import cpu_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR load and PC+4 happen together, only on the cycle the
                // fetch completes, so a stalled fetch never advances the PC.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut.
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle datapath. Walks each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath
// controls. Halts in TRAP on an unrecognised opcode until reset.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   opcode              instruction[31:26] from the IR
//   mem_ready           memory finishes the current access this cycle
//   pc_write .. pc_source  datapath enables and mux selects
//   state               current state (debug)
//   illegal_op          high while trapped
module multicycle_main_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int ST_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [ST_W-1:0]  state,
    output logic             illegal_op
);

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    ctrl_t            ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                // The IR is stable here; capture the opcode so later states
                // do not depend on the live IR output.
                opc_d = opcode;
                case (opcode)
                    OPC_W'(OP_RTYPE):         state_d = S_EXEC_R;
                    OPC_W'(OP_LW),
                    OPC_W'(OP_SW):            state_d = S_MEM_ADDR;
                    OPC_W'(OP_BEQ):           state_d = S_BRANCH;
                    OPC_W'(OP_J):             state_d = S_JUMP;
                    OPC_W'(OP_ADDI):          state_d = S_ADDI_EX;
                    default:                  state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (opc_q == OPC_W'(OP_SW)) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            // Encodings 14/15 are unreachable; treat a corrupted state as fatal.
            default:    state_d = S_TRAP;
        endcase
    end

    main_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = ST_W'(state_q);

endmodule
